uart_serial: RTL and testbench
==============================

UART_SERIAL -- requirements
Module: uart_serial

Interface
REQ-001 Parameter ClockFreq, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BaudRate, default 115200, serial bit rate.
REQ-003 Clock  input  1  single system clock; all state on rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 DataIn  input  8  byte to transmit (from MMIO decoder Write).
REQ-006 DataInValid  input  1  transmit request, qualified by DataInReady.
REQ-007 DataInReady  output  1  transmitter idle, can accept a byte.
REQ-008 DataOut  output  8  last received byte (to MMIO decoder Read).
REQ-009 DataOutValid  output  1  DataOut holds an unconsumed byte.
REQ-010 DataOutReady  input  1  consumer takes DataOut this cycle.
REQ-011 SIn  input  1  serial receive line, idle high, asynchronous to Clock.
REQ-012 SOut  output  1  serial transmit line, idle high.

Function
REQ-013 SymbolEdgeTime = ClockFreq/BaudRate (integer division, truncated); SampleTime = SymbolEdgeTime/2; counter width = clog2(SymbolEdgeTime)+1.
REQ-014 Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-015 TX states IDLE, START, DATA, STOP; each non-IDLE bit lasts exactly SymbolEdgeTime cycles.
REQ-016 TX handshake: byte accepted on the rising edge where DataInValid && DataInReady; DataIn captured into shift register on that edge.
REQ-017 DataInReady high only in IDLE; deasserts the cycle after acceptance; reasserts the cycle after STOP completes.
REQ-018 SOut drives 0 starting the cycle after acceptance (1-cycle latency); SOut high in IDLE and STOP.
REQ-019 DataInValid while DataInReady low is ignored; no queuing.
REQ-020 SIn passes a 2-flop synchroniser before any use.
REQ-021 RX states IDLE, START, DATA, STOP; IDLE->START on synchronised SIn falling to 0.
REQ-022 START: SIn resampled at SampleTime; if 1, glitch -> back to IDLE, no byte produced.
REQ-023 DATA: each bit sampled at mid-bit (SymbolEdgeTime after previous sample); 8 samples shifted LSB-first.
REQ-024 STOP: sampled at mid-bit; 1 -> byte valid; 0 -> framing error, byte discarded, DataOutValid unchanged.
REQ-025 On valid stop bit, if DataOutValid low: DataOut <= byte, DataOutValid <= 1 on next edge.
REQ-026 Overrun: if DataOutValid high and DataOutReady low at stop sample, new byte is dropped; old DataOut retained.
REQ-027 Simultaneous: DataOutReady high on same edge as valid stop sample -> new byte loaded, DataOutValid stays 1.
REQ-028 DataOutReady with DataOutValid high clears DataOutValid next edge; DataOutReady with DataOutValid low has no effect.
REQ-029 RX returns to IDLE after stop sample and accepts the next start edge immediately (no half-bit dead time beyond stop sample).
REQ-030 TX and RX fully independent; full-duplex operation required.

Reset
REQ-031 Reset_n low asynchronously forces TX and RX to IDLE, counters 0, SOut=1, DataInReady=1 after release, DataOut=8'h00, DataOutValid=0, synchroniser flops=1.
REQ-032 Reset mid-frame aborts the frame; no partial byte ever appears on DataOut; SOut returns high immediately.

Structure
REQ-033 Shared package holds TX/RX state encodings and the SymbolEdgeTime/SampleTime/counter-width computation as constant functions.
REQ-034 Receiver is one sub-module, uart_receiver; transmitter logic and handshake glue live in uart_serial.

Verification (ClockFreq=1000, BaudRate=100 -> 10 cycles/bit)
REQ-035 Send DataIn=8'hA5 with DataInValid 1 cycle -> SOut = 0,1,0,1,0,0,1,0,1,1 each 10 cycles; DataInReady low 100 cycles.
REQ-036 Loop SOut to SIn, send 8'h3C -> DataOutValid rises with DataOut=8'h3C; DataOutReady pulse clears it next cycle.
REQ-037 Two frames 8'h11, 8'h22 received with DataOutReady held low -> DataOut stays 8'h11 (overrun drop); repeat with DataOutReady pulsed on second stop sample -> DataOut=8'h22, DataOutValid stays 1.
REQ-038 SIn low for 3 cycles then high -> no DataOutValid; frame with stop bit 0 -> no DataOutValid.
REQ-039 Assert Reset_n low at TX bit 4 and RX bit 4 -> SOut=1, DataOutValid=0, DataInReady=1 after release; next full frame received correctly.

Source files
------------

// File: rtl/uart_serial_pkg.sv
// Shared definitions for the UART: TX/RX state encodings and the bit-timing
// arithmetic that turns a clock frequency and baud rate into counter limits.
package uart_serial_pkg;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Clock cycles per serial bit, truncated.
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Offset from a detected start edge to the middle of the start bit.
    function automatic int sample_time(input int clock_freq, input int baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

    // Width of the bit-timing counters, with one bit of headroom.
    function automatic int counter_width(input int clock_freq, input int baud_rate);
        return $clog2(symbol_edge_time(clock_freq, baud_rate)) + 1;
    endfunction

endpackage

// File: rtl/uart_receiver.sv
// UART receiver: synchronises the serial line, finds the start bit, samples
// each bit at its centre and flags a completed frame with a good stop bit.
module uart_receiver
    import uart_serial_pkg::*;
#(
    parameter int ClockFreq = 50000000,
    parameter int BaudRate  = 115200
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       line,
    output logic [7:0] data,
    output logic       done
);

    localparam int Cw = counter_width(ClockFreq, BaudRate);
    localparam logic [Cw-1:0] BitLast    = Cw'(symbol_edge_time(ClockFreq, BaudRate) - 1);
    localparam logic [Cw-1:0] SampleLast = Cw'(sample_time(ClockFreq, BaudRate) - 1);

    logic [1:0]    sync;
    logic          rx;
    logic [1:0]    state;
    logic [Cw-1:0] count;
    logic [2:0]    bit_index;
    logic [7:0]    shift;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], line};
        end
    end

    assign rx = sync[1];

    // Frame state machine: half-bit to the start-bit centre, then whole bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RX_IDLE;
            count     <= '0;
            bit_index <= '0;
            shift     <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    count     <= '0;
                    bit_index <= '0;
                    if (!rx) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (count == SampleLast) begin
                        count <= '0;
                        state <= rx ? RX_IDLE : RX_DATA;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (count == BitLast) begin
                        count     <= '0;
                        shift     <= {rx, shift[7:1]};
                        bit_index <= bit_index + 1'b1;
                        if (bit_index == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    if (count == BitLast) begin
                        count <= '0;
                        state <= RX_IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
            endcase
        end
    end

    assign data = shift;
    assign done = (state == RX_STOP) && (count == BitLast) && rx;

endmodule

// File: rtl/uart_serial.sv
// Full-duplex UART with a valid/ready byte interface on each side. The
// transmitter and the receive-side holding register live here; bit recovery
// is delegated to uart_receiver.
module uart_serial
    import uart_serial_pkg::*;
#(
    parameter int ClockFreq = 50000000,
    parameter int BaudRate  = 115200
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic [7:0] DataOut,
    output logic       DataOutValid,
    input  logic       DataOutReady,
    input  logic       SIn,
    output logic       SOut
);

    localparam int Cw = counter_width(ClockFreq, BaudRate);
    localparam logic [Cw-1:0] BitLast = Cw'(symbol_edge_time(ClockFreq, BaudRate) - 1);

    logic [1:0]    tx_state;
    logic [Cw-1:0] tx_count;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_line;
    logic [7:0]    rx_data;
    logic          rx_done;

    assign DataInReady = (tx_state == TX_IDLE);
    assign SOut        = tx_line;

    // Transmit state machine; the line is registered so it is glitch-free.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_state <= TX_IDLE;
            tx_count <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_count <= '0;
                    tx_bit   <= '0;
                    tx_line  <= 1'b1;
                    if (DataInValid) begin
                        tx_shift <= DataIn;
                        tx_line  <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_count == BitLast) begin
                        tx_count <= '0;
                        tx_line  <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_state <= TX_DATA;
                    end else begin
                        tx_count <= tx_count + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_count == BitLast) begin
                        tx_count <= '0;
                        tx_bit   <= tx_bit + 1'b1;
                        if (tx_bit == 3'd7) begin
                            tx_line  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_line  <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_count <= tx_count + 1'b1;
                    end
                end
                default: begin
                    if (tx_count == BitLast) begin
                        tx_count <= '0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_count <= tx_count + 1'b1;
                    end
                end
            endcase
        end
    end

    uart_receiver #(
        .ClockFreq(ClockFreq),
        .BaudRate (BaudRate)
    ) receiver (
        .clock  (Clock),
        .reset_n(Reset_n),
        .line   (SIn),
        .data   (rx_data),
        .done   (rx_done)
    );

    // Receive holding register: a new byte is taken only if the slot is free
    // or being emptied on the same edge; otherwise it is dropped (overrun).
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            DataOut      <= 8'h00;
            DataOutValid <= 1'b0;
        end else if (rx_done && (!DataOutValid || DataOutReady)) begin
            DataOut      <= rx_data;
            DataOutValid <= 1'b1;
        end else if (DataOutReady) begin
            DataOutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_serial.sv
// Bench for uart_serial at 10 clocks per bit. Received bytes are checked
// against a queue of bytes the bench expects to arrive, in order.
module tb_uart_serial;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b0;
    logic       rx_line = 1'b1;
    logic       loop_back = 1'b0;
    logic       serial_in;
    logic       serial_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] expected_q[$];

    assign serial_in = loop_back ? serial_out : rx_line;

    uart_serial #(
        .ClockFreq(1000),
        .BaudRate (100)
    ) dut (
        .Clock       (clock),
        .Reset_n     (reset_n),
        .DataIn      (data_in),
        .DataInValid (data_in_valid),
        .DataInReady (data_in_ready),
        .DataOut     (data_out),
        .DataOutValid(data_out_valid),
        .DataOutReady(data_out_ready),
        .SIn         (serial_in),
        .SOut        (serial_out)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one byte to the transmitter; returns just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] value);
        int waited;
        waited = 0;
        @(negedge clock);
        while (!data_in_ready && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("tx_ready_wait", 32'(data_in_ready), 32'd1);
        data_in = value;
        data_in_valid = 1'b1;
        @(posedge clock);
        #1;
        data_in_valid = 1'b0;
    endtask

    task automatic waitValid(input int max_cycles);
        int waited;
        waited = 0;
        while (!data_out_valid && waited < max_cycles) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("rx_valid_wait", 32'(data_out_valid), 32'd1);
    endtask

    task automatic consume();
        data_out_ready = 1'b1;
        @(negedge clock);
        data_out_ready = 1'b0;
        checkOutput("rx_consumed", 32'(data_out_valid), 32'd0);
    endtask

    // Bit-bang a frame onto the receive line with a chosen stop-bit level.
    task automatic driveRawFrame(input logic [7:0] value, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, value, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_line = frame[i];
            repeat (10) @(negedge clock);
        end
        rx_line = 1'b1;
    endtask

    // Scoreboard monitor: every newly loaded DataOut must match the queue head.
    initial begin
        logic       prev_valid;
        logic [7:0] prev_out;
        prev_valid = 1'b0;
        prev_out = 8'h00;
        forever begin
            @(negedge clock);
            if (data_out_valid === 1'b1 && (!prev_valid || data_out != prev_out)) begin
                checkOutput("rx_expected_pending", 32'(expected_q.size() != 0), 32'd1);
                if (expected_q.size() != 0) begin
                    checkOutput("rx_byte", 32'(data_out), 32'(expected_q.pop_front()));
                end
            end
            prev_valid = (data_out_valid === 1'b1);
            prev_out = data_out;
        end
    end

    initial begin
        logic [9:0] frame;
        int low_cycles;
        logic valid_dropped;

        // Reset state
        repeat (2) @(negedge clock);
        checkOutput("rst_sout", 32'(serial_out), 32'd1);
        checkOutput("rst_out_valid", 32'(data_out_valid), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("rst_in_ready", 32'(data_in_ready), 32'd1);
        checkOutput("rst_data_out", 32'(data_out), 32'd0);

        // Transmit 0xA5 and inspect each bit at its centre
        frame = {1'b1, 8'hA5, 1'b0};
        low_cycles = 0;
        applyStimulus(8'hA5);
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (n % 10 == 5) begin
                checkOutput($sformatf("tx_a5_bit%0d", n / 10), 32'(serial_out), 32'(frame[n / 10]));
            end
            if (n == 30) begin
                data_in = 8'hFF;
                data_in_valid = 1'b1;
            end
            if (n == 31) begin
                data_in_valid = 1'b0;
            end
            if (!data_in_ready) begin
                low_cycles++;
            end
        end
        @(negedge clock);
        checkOutput("tx_ready_back", 32'(data_in_ready), 32'd1);
        checkOutput("tx_ready_low_cycles", 32'(low_cycles), 32'd100);
        repeat (5) @(negedge clock);
        checkOutput("tx_busy_req_ignored_ready", 32'(data_in_ready), 32'd1);
        checkOutput("tx_busy_req_ignored_line", 32'(serial_out), 32'd1);

        // Loopback 0x3C
        loop_back = 1'b1;
        expected_q.push_back(8'h3C);
        applyStimulus(8'h3C);
        waitValid(300);
        checkOutput("loop_3c", 32'(data_out), 32'h3C);
        consume();

        // Overrun: second byte dropped while the first is unconsumed
        expected_q.push_back(8'h11);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        repeat (110) @(negedge clock);
        checkOutput("overrun_data", 32'(data_out), 32'h11);
        checkOutput("overrun_valid", 32'(data_out_valid), 32'd1);
        consume();

        // Consume on the very edge of the second stop sample. Stop sample is
        // 98 edges after acceptance: 2 synchroniser edges, 1 detect edge,
        // 5 to start-bit centre, then 9 bits of 10.
        expected_q.push_back(8'h11);
        expected_q.push_back(8'h22);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        valid_dropped = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (!data_out_valid) begin
                valid_dropped = 1'b1;
            end
            if (n == 97) begin
                data_out_ready = 1'b1;
            end
            if (n == 98) begin
                data_out_ready = 1'b0;
                checkOutput("simul_data", 32'(data_out), 32'h22);
            end
        end
        checkOutput("simul_valid_held", 32'(valid_dropped), 32'd0);
        consume();

        // Start-bit glitch and framing error produce nothing
        loop_back = 1'b0;
        rx_line = 1'b0;
        repeat (3) @(negedge clock);
        rx_line = 1'b1;
        repeat (30) @(negedge clock);
        checkOutput("glitch_no_valid", 32'(data_out_valid), 32'd0);
        driveRawFrame(8'h5A, 1'b0);
        repeat (20) @(negedge clock);
        checkOutput("framing_no_valid", 32'(data_out_valid), 32'd0);
        expected_q.push_back(8'h96);
        driveRawFrame(8'h96, 1'b1);
        waitValid(50);
        checkOutput("raw_96", 32'(data_out), 32'h96);
        repeat (10) @(negedge clock);

        // Reset in the middle of data bit 4 with a byte still held
        loop_back = 1'b1;
        applyStimulus(8'hE7);
        repeat (56) @(negedge clock);
        checkOutput("mid_frame_line", 32'(serial_out), 32'd0);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_sout", 32'(serial_out), 32'd1);
        checkOutput("mid_rst_valid", 32'(data_out_valid), 32'd0);
        checkOutput("mid_rst_data", 32'(data_out), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("post_rst_ready", 32'(data_in_ready), 32'd1);
        checkOutput("post_rst_sout", 32'(serial_out), 32'd1);
        repeat (120) @(negedge clock);
        checkOutput("post_rst_no_partial", 32'(data_out_valid), 32'd0);
        expected_q.push_back(8'hC3);
        applyStimulus(8'hC3);
        waitValid(300);
        checkOutput("post_rst_c3", 32'(data_out), 32'hC3);
        consume();

        repeat (5) @(negedge clock);
        checkOutput("sb_empty", 32'(expected_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
